// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the single-port memory arbiter
package mem_port_arbiter_pkg;

  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_DATA_W       = 32;
  localparam int ARB_BE_W         = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_MEM
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - MEM-first priority select with IF anti-starvation override
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             if_req,
  input  logic             mem_req,
  input  logic [CNT_W-1:0] streak,
  output logic             pick_if,
  output logic             pick_mem
);

  logic starved;

  assign starved  = if_req && (streak == CNT_W'(STARVE_LIMIT));
  assign pick_mem = mem_req && !starved;
  assign pick_if  = if_req && !pick_mem;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter onto one single-port memory; MEM_ARB_STATS_EN adds stall counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_mem_req,
  input  logic                i_mem_we,
  input  logic [DATA_W/8-1:0] i_mem_be,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  output logic                o_mem_gnt,
  output logic                o_mem_rvalid,
  output logic [DATA_W-1:0]   o_mem_rdata,
  output logic                o_ram_req,
  output logic                o_ram_we,
  output logic [DATA_W/8-1:0] o_ram_be,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W-1:0]   o_ram_wdata,
  input  logic                i_ram_ack,
  input  logic [DATA_W-1:0]   i_ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         o_if_stall_cnt,
  output logic [31:0]         o_mem_stall_cnt
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q, state_d;
  ram_req_t         req_q, req_d;
  logic [CNT_W-1:0] streak_q;
  logic [DATA_W-1:0] rdata_q;
  logic             if_rvalid_q, mem_rvalid_q;
  logic             idle, busy, pick_if, pick_mem;

  // Gating with reset keeps the combinational grants low while reset is held.
  assign idle = (state_q == ARB_IDLE) && i_reset_n;
  assign busy = (state_q != ARB_IDLE);

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .if_req   (i_if_req && idle),
    .mem_req  (i_mem_req && idle),
    .streak   (streak_q),
    .pick_if  (pick_if),
    .pick_mem (pick_mem)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_mem) begin
          state_d     = ARB_MEM;
          req_d.we    = i_mem_we;
          req_d.be    = ARB_BE_W'(i_mem_be);
          req_d.addr  = ARB_ADDR_W'(i_mem_addr);
          req_d.wdata = ARB_DATA_W'(i_mem_wdata);
        end else if (pick_if) begin
          state_d     = ARB_IF;
          req_d.we    = 1'b0;
          req_d.be    = '1;
          req_d.addr  = ARB_ADDR_W'(i_if_addr);
          req_d.wdata = '0;
        end
      end
      ARB_IF, ARB_MEM: begin
        if (i_ram_ack) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if_rvalid_q  <= (state_q == ARB_IF) && i_ram_ack;
      mem_rvalid_q <= (state_q == ARB_MEM) && i_ram_ack;
      if (busy && i_ram_ack)
        rdata_q <= ((state_q == ARB_MEM) && req_q.we) ? '0 : i_ram_rdata;
    end
  end

  // Streak counts MEM wins only while IF is actually waiting.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      streak_q <= '0;
    end else if (!i_if_req || pick_if) begin
      streak_q <= '0;
    end else if (pick_mem && (streak_q != CNT_W'(STARVE_LIMIT))) begin
      streak_q <= streak_q + CNT_W'(1);
    end
  end

  assign o_if_gnt     = pick_if;
  assign o_mem_gnt    = pick_mem;
  assign o_if_rvalid  = if_rvalid_q;
  assign o_mem_rvalid = mem_rvalid_q;
  assign o_if_rdata   = if_rvalid_q ? rdata_q : '0;
  assign o_mem_rdata  = mem_rvalid_q ? rdata_q : '0;
  assign o_ram_req    = busy;
  assign o_ram_we     = busy && req_q.we;
  assign o_ram_be     = busy ? BE_W'(req_q.be) : '0;
  assign o_ram_addr   = busy ? ADDR_W'(req_q.addr) : '0;
  assign o_ram_wdata  = busy ? DATA_W'(req_q.wdata) : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_stall_q, mem_stall_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if_stall_q  <= '0;
      mem_stall_q <= '0;
    end else begin
      if (i_if_req && !pick_if && (if_stall_q != '1))
        if_stall_q <= if_stall_q + 32'd1;
      if (i_mem_req && !pick_mem && (mem_stall_q != '1))
        mem_stall_q <= mem_stall_q + 32'd1;
    end
  end

  assign o_if_stall_cnt  = if_stall_q;
  assign o_mem_stall_cnt = mem_stall_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF) and data access (MEM) for the synthesis build, where no dual-port memory exists.
- Sits between the IF stage / mem_top and the physical memory.
- Serialises requests with one transaction outstanding; MEM has priority and IF has an anti-starvation guard.
- Returns read data and write completion to the owning requester.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits before IF is forced through (≥1).

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_if_req  in  1  IF request; held with i_if_addr until granted.
- i_if_addr  in  ADDR_W  IF read address.
- o_if_gnt  out  1  IF request accepted (1-cycle pulse).
- o_if_rvalid  out  1  IF read data valid (1-cycle pulse).
- o_if_rdata  out  DATA_W  IF read data.
- i_mem_req  in  1  MEM request; held with its fields until granted.
- i_mem_we  in  1  MEM write (1) / read (0).
- i_mem_be  in  DATA_W/8  MEM byte enables.
- i_mem_addr  in  ADDR_W  MEM address.
- i_mem_wdata  in  DATA_W  MEM write data.
- o_mem_gnt  out  1  MEM request accepted (1-cycle pulse).
- o_mem_rvalid  out  1  MEM completion (read data valid, or write done).
- o_mem_rdata  out  DATA_W  MEM read data (0 for writes).
- o_ram_req  out  1  memory request; held until i_ram_ack.
- o_ram_we  out  1  memory write.
- o_ram_be  out  DATA_W/8  memory byte enables.
- o_ram_addr  out  ADDR_W  memory address.
- o_ram_wdata  out  DATA_W  memory write data.
- i_ram_ack  in  1  memory done; i_ram_rdata valid in the same cycle for reads.
- i_ram_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: single clock i_clk; i_reset_n is asynchronous, active-low.
- Reset values: every output 0; state IDLE; streak counter 0.
- Reset mid-transaction: the transaction is dropped, o_ram_req falls immediately, and no rvalid is issued.
- FSM IDLE:
  - Grant is combinational.
  - Pick MEM if i_mem_req, unless (i_if_req && streak==STARVE_LIMIT), in which case pick IF. Otherwise pick IF if i_if_req.
  - Winner's gnt pulses this cycle; fields are registered. Next state is IF_ACC or MEM_ACC.
- FSM IF_ACC / MEM_ACC:
  - o_ram_* driven from registers; o_ram_req=1 until i_ram_ack.
  - On ack: capture rdata (forced to 0 for MEM writes), go to IDLE.
  - Next cycle: owner's rvalid=1 with rdata.
- Latency: req at cycle 0 in IDLE → gnt cycle 0 → o_ram_req cycle 1 → earliest ack cycle 1 → rvalid cycle 2.
- Back-to-back: a new grant is allowed in the same IDLE cycle that rvalid is shown.
- Minimum issue interval is 2 cycles; no gnt outside IDLE.
- Streak counter:
  - Increments (saturating at STARVE_LIMIT) on each MEM grant while i_if_req=1.
  - Clears on IF grant, or in any cycle i_if_req=0.
- Simultaneous requests with streak<STARVE_LIMIT: MEM wins.
- No address or alignment checks; i_mem_be passes unchanged. IF reads drive o_ram_be all-ones, we=0, wdata=0.
- Requests dropped before grant are legal and leave no side effects.
- Request field changes before grant: the value sampled in the grant cycle is used.
- Memory that never acks: the FSM holds indefinitely (no timeout).

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds ports o_if_stall_cnt and o_mem_stall_cnt (32-bit out).
  - Each counts cycles where its req=1 and gnt=0, saturating at 2^32-1.
  - Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared core package:
  - arb_state_t enum {ARB_IDLE, ARB_IF, ARB_MEM}.
  - ram_req_t struct {we, be, addr, wdata}.
  - Default constant ARB_STARVE_LIMIT=4.
- Sub-module mem_arb_pick: combinational priority select (reqs, streak → pick_if, pick_mem).
- FSM, registers and counters stay in mem_port_arbiter.

Test Plan:
- IF-only read: IF read 0x100, ack 1 cycle later with 0xDEADBEEF → o_if_gnt cycle 0, o_ram_req cycles 1–1, o_if_rvalid cycle 2 with o_if_rdata=0xDEADBEEF; MEM outputs stay 0.
- Simultaneous requests: IF and MEM request together, MEM write be=4'b0011 data 0x1234 → MEM granted first; o_ram_we=1, be=0011; o_mem_rvalid with rdata=0; IF granted the cycle MEM rvalid shows.
- Starvation guard: MEM requests continuously with IF held and immediate ack → exactly 4 MEM grants, then an IF grant, then MEM resumes.
- Wait states: ack delayed 5 cycles → o_ram_req/addr stable for 5 cycles, no gnt during busy, rvalid 1 cycle after ack.
- Reset mid-transaction: reset asserted in MEM_ACC → all outputs 0 asynchronously; after release, no stray rvalid; a fresh IF request completes normally.
- With MEM_ARB_STATS_EN: MEM holds memory 6 cycles while IF waits → o_if_stall_cnt=6, o_mem_stall_cnt=0.
